// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered, frame-aligned updates.
// Define SEG7_HEX_EN to show magnitudes 10..15 as hex letters instead of a dash.
module seg7_scan_display #(
  parameter int N      = 4,
  parameter int W      = 2,
  parameter int SIGNED = 1,
  parameter int DWELL  = 1024,
  parameter int GUARD  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic [6:0]     seg,
  output logic [N-1:0]   digit_sel,
  output logic           seg_neg,
  output logic           frame_done,
  output logic           scanning
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(DWELL);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [N*W-1:0]    r_active;
  logic [N*W-1:0]    r_pending;
  logic              r_pendFlag;
  logic [IDXW-1:0]   r_idx;
  logic [CNTW-1:0]   r_cnt;

  state_t            w_nextState;
  logic [N*W-1:0]    w_nextActive;
  logic [N*W-1:0]    w_nextPending;
  logic              w_nextPendFlag;
  logic [IDXW-1:0]   w_nextIdx;
  logic [CNTW-1:0]   w_nextCnt;

  logic              w_xfer;
  logic              w_dwellEnd;
  logic              w_lastDigit;
  logic              w_frameEnd;
  logic              w_guardOk;
  logic [W-1:0]      w_elem;
  logic [W:0]        w_ext;
  logic [W:0]        w_mag;
  logic [4:0]        w_mag5;
  logic              w_neg;

  assign w_xfer      = in_valid && !r_pendFlag;
  assign w_dwellEnd  = (r_cnt == CNTW'(DWELL - 1));
  assign w_lastDigit = (r_idx == IDXW'(N - 1));
  assign w_frameEnd  = w_dwellEnd && w_lastDigit;

  // The first GUARD cycles of every dwell blank the digits so the segment
  // lines can settle on the new glyph before the next digit lights.
  if (GUARD == 0) begin : g_noGuard
    assign w_guardOk = 1'b1;
  end else begin : g_guard
    assign w_guardOk = (r_cnt >= CNTW'(GUARD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_BLANK;
      r_active   <= '0;
      r_pending  <= '0;
      r_pendFlag <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_nextState;
      r_active   <= w_nextActive;
      r_pending  <= w_nextPending;
      r_pendFlag <= w_nextPendFlag;
      r_idx      <= w_nextIdx;
      r_cnt      <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextActive   = r_active;
    w_nextPending  = r_pending;
    w_nextPendFlag = r_pendFlag;
    w_nextIdx      = r_idx;
    w_nextCnt      = r_cnt;
    case (r_state)
      ST_BLANK: begin
        if (w_xfer) begin
          w_nextActive = in_data;
          w_nextIdx    = '0;
          w_nextCnt    = '0;
          w_nextState  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_dwellEnd) begin
          w_nextCnt = '0;
          w_nextIdx = w_lastDigit ? '0 : r_idx + IDXW'(1);
        end else begin
          w_nextCnt = r_cnt + CNTW'(1);
        end
        // Active data only changes at frame end, so a frame never mixes old and new values.
        if (w_frameEnd) begin
          if (r_pendFlag) begin
            w_nextActive   = r_pending;
            w_nextPendFlag = 1'b0;
          end else if (w_xfer) begin
            w_nextActive = in_data;
          end
        end else if (w_xfer) begin
          w_nextPending  = in_data;
          w_nextPendFlag = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IDXW'(k)) w_elem = r_active[k*W +: W];
    end
  end

  // Magnitude is formed one bit wider so the most negative value negates cleanly.
  always_comb begin
    w_ext = {1'b0, w_elem};
    w_neg = 1'b0;
    if (SIGNED != 0) begin
      w_neg = w_elem[W-1];
      w_ext = {w_elem[W-1], w_elem};
    end
    w_mag  = w_neg ? -w_ext : w_ext;
    w_mag5 = 5'(w_mag);
  end

  function automatic logic [6:0] glyph(input logic [4:0] mag);
    logic [6:0] g;
    case (mag)
      5'd0:    g = 7'h3F;
      5'd1:    g = 7'h06;
      5'd2:    g = 7'h5B;
      5'd3:    g = 7'h4F;
      5'd4:    g = 7'h66;
      5'd5:    g = 7'h6D;
      5'd6:    g = 7'h7D;
      5'd7:    g = 7'h07;
      5'd8:    g = 7'h7F;
      5'd9:    g = 7'h6F;
`ifdef SEG7_HEX_EN
      5'd10:   g = 7'h77;
      5'd11:   g = 7'h7C;
      5'd12:   g = 7'h39;
      5'd13:   g = 7'h5E;
      5'd14:   g = 7'h79;
      5'd15:   g = 7'h71;
`endif
      default: g = 7'h40;
    endcase
    return g;
  endfunction

  always_comb begin
    in_ready   = !r_pendFlag;
    seg        = '0;
    digit_sel  = '0;
    seg_neg    = 1'b0;
    frame_done = 1'b0;
    scanning   = 1'b0;
    if (r_state == ST_SCAN) begin
      scanning   = 1'b1;
      seg        = glyph(w_mag5);
      seg_neg    = w_neg;
      frame_done = w_frameEnd;
      if (w_guardOk) digit_sel = N'(1) << r_idx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized self-checking bench for seg7_scan_display against a frame-tick reference model,
// plus a second small instance exercising the 4-bit unsigned glyph path.
module tb_seg7_scan_display;

  localparam int N     = 4;
  localparam int W     = 2;
  localparam int DWELL = 4;
  localparam int GUARD = 1;
  localparam int FRAME = N * DWELL;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [6:0]     seg;
  logic [N-1:0]   digit_sel;
  logic           seg_neg;
  logic           frame_done;
  logic           scanning;

  logic           rst2;
  logic           in2Valid;
  logic           in2Ready;
  logic [3:0]     in2Data;
  logic [6:0]     seg2;
  logic [0:0]     sel2;
  logic           neg2;
  logic           fd2;
  logic           scan2;

  int total = 0;
  int bad   = 0;

  // Reference model: whole-frame view, position is a single tick 0..FRAME-1.
  bit mScan;
  int mAct[N];
  int mPend[N];
  bit mPendValid;
  int mTick;
  int glyphTab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  always #5 clk = ~clk;

  seg7_scan_display #(.N(N), .W(W), .SIGNED(1), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .seg(seg), .digit_sel(digit_sel), .seg_neg(seg_neg), .frame_done(frame_done),
    .scanning(scanning)
  );

  seg7_scan_display #(.N(1), .W(4), .SIGNED(0), .DWELL(2), .GUARD(0)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in2Valid), .in_ready(in2Ready), .in_data(in2Data),
    .seg(seg2), .digit_sel(sel2), .seg_neg(neg2), .frame_done(fd2), .scanning(scan2)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int elemVal(input logic [N*W-1:0] d, input int k);
    int e = 0;
    for (int b = 0; b < W; b++) if (d[k*W + b]) e += (1 << b);
    if (e >= (1 << (W - 1))) e -= (1 << W);
    return e;
  endfunction

  task automatic checkAll();
    int dig, ph, v, mag;
    if (!mScan) begin
      checkOutput("seg", 32'(seg), 0);
      checkOutput("digit_sel", 32'(digit_sel), 0);
      checkOutput("seg_neg", 32'(seg_neg), 0);
      checkOutput("frame_done", 32'(frame_done), 0);
      checkOutput("scanning", 32'(scanning), 0);
      checkOutput("in_ready", 32'(in_ready), 1);
    end else begin
      dig = mTick / DWELL;
      ph  = mTick % DWELL;
      v   = mAct[dig];
      mag = (v < 0) ? -v : v;
      checkOutput("seg", 32'(seg), 32'(glyphTab[mag]));
      checkOutput("digit_sel", 32'(digit_sel), (ph >= GUARD) ? 32'(1 << dig) : 0);
      checkOutput("seg_neg", 32'(seg_neg), (v < 0) ? 1 : 0);
      checkOutput("frame_done", 32'(frame_done), (mTick == FRAME - 1) ? 1 : 0);
      checkOutput("scanning", 32'(scanning), 1);
      checkOutput("in_ready", 32'(in_ready), mPendValid ? 0 : 1);
    end
  endtask

  task automatic modelStep(input logic v, input logic [N*W-1:0] d, input logic r);
    bit accept;
    if (r) begin
      mScan = 0; mPendValid = 0; mTick = 0;
      for (int k = 0; k < N; k++) begin mAct[k] = 0; mPend[k] = 0; end
    end else if (!mScan) begin
      if (v) begin
        for (int k = 0; k < N; k++) mAct[k] = elemVal(d, k);
        mScan = 1; mTick = 0;
      end
    end else begin
      accept = v && !mPendValid;
      if (mTick == FRAME - 1) begin
        if (mPendValid) begin
          mAct = mPend;
          mPendValid = 0;
        end else if (accept) begin
          for (int k = 0; k < N; k++) mAct[k] = elemVal(d, k);
        end
        mTick = 0;
      end else begin
        if (accept) begin
          for (int k = 0; k < N; k++) mPend[k] = elemVal(d, k);
          mPendValid = 1;
        end
        mTick++;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [N*W-1:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    rst      = r;
    modelStep(v, d, r);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic runUntilTick(input int t);
    int n = 0;
    while (!(mScan && mTick == t && !mPendValid) && n < 200) begin
      applyStimulus(1'b0, '0, 1'b0);
      n++;
    end
    checkOutput("waitBound", 32'(n < 200), 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    rst2 = 1'b1; in2Valid = 1'b0; in2Data = '0;
    mScan = 0; mPendValid = 0; mTick = 0;
    for (int k = 0; k < N; k++) begin mAct[k] = 0; mPend[k] = 0; end
    @(negedge clk);

    repeat (2) applyStimulus(1'b0, '0, 1'b1);
    repeat (20) applyStimulus(1'b0, '0, 1'b0);

    applyStimulus(1'b1, 8'b10_01_11_00, 1'b0);
    checkOutput("firstSeg", 32'(seg), 32'h3F);
    checkOutput("firstGuard", 32'(digit_sel), 0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("firstSel", 32'(digit_sel), 32'b0001);

    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    repeat (3) applyStimulus(1'b1, 8'hFF, 1'b0);
    repeat (2 * FRAME) applyStimulus(1'b0, '0, 1'b0);

    runUntilTick(FRAME - 1);
    applyStimulus(1'b1, 8'b00_01_00_01, 1'b0);
    checkOutput("coincReady", 32'(in_ready), 1);
    repeat (FRAME) applyStimulus(1'b0, '0, 1'b0);

    runUntilTick(2 * DWELL + 1);
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) applyStimulus(1'b0, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) == 0, N*W'($urandom), ($urandom % 150) == 0);
    end

    rst2 = 1'b0; in2Valid = 1'b1; in2Data = 4'h8;
    @(posedge clk); @(negedge clk);
    checkOutput("u8seg", 32'(seg2), 32'h7F);
    checkOutput("u8neg", 32'(neg2), 0);
    checkOutput("u8sel", 32'(sel2), 1);
    rst2 = 1'b1; in2Valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("u8rst", 32'(scan2), 0);
    rst2 = 1'b0; in2Valid = 1'b1; in2Data = 4'hB;
    @(posedge clk); @(negedge clk);
`ifdef SEG7_HEX_EN
    checkOutput("uBseg", 32'(seg2), 32'h7C);
`else
    checkOutput("uBseg", 32'(seg2), 32'h40);
`endif
    in2Valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Time-multiplexed driver for an N-digit 7-segment display fed with a packed vector of N small integer elements, e.g. matrix-multiplier results. Each element is shown as one digit, with its sign on a shared minus-sign output, by scanning the digits one at a time at a programmable dwell.
- Input uses a valid/ready handshake.
- Updates are double-buffered and applied only at frame boundaries, so the display never tears.
- Sits between the matrix datapath and the pad-level segment/digit pins.

Parameters:
N, 4, number of elements/digits (1..8)
W, 2, bits per element (2..4)
SIGNED, 1, 1 = elements are two's complement, 0 = unsigned
DWELL, 1024, clock cycles each digit is displayed (>= 2)
GUARD, 1, cycles at start of each dwell with digit_sel forced to 0 for anti-ghosting (0..DWELL-1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data
in_data  input  N*W  packed elements; element k = in_data[k*W +: W]
seg  output  7  active-high segments; seg[0]=top, [1]=upper right, [2]=lower right, [3]=bottom, [4]=lower left, [5]=upper left, [6]=middle
digit_sel  output  N  one-hot active-high digit enable, bit k = element k
seg_neg  output  1  minus-sign indicator for the currently displayed element
frame_done  output  1  one-cycle pulse on the last cycle of each frame
scanning  output  1  high once the first data has been accepted

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. No other clock or reset.
- Outputs are combinational decodes of registered state only. There is no input-to-output combinational path except in_ready, which depends only on registers.
- Reset values: state = BLANK, active and pending buffers = 0, pending_flag = 0, idx = 0, cnt = 0. Outputs: seg = 0, digit_sel = 0, seg_neg = 0, frame_done = 0, scanning = 0, in_ready = 1.
- A transfer occurs when in_valid && in_ready. in_ready = !pending_flag.
- BLANK state:
  - Outputs stay at reset values.
  - A transfer loads the active buffer directly and sets idx = 0, cnt = 0, state = SCAN.
  - Digit 0 is driven on the following cycle (latency 1).
- SCAN state:
  - cnt counts 0..DWELL-1. At DWELL-1, cnt wraps to 0 and idx advances, wrapping from N-1 to 0.
  - digit_sel = one-hot(idx) when cnt >= GUARD, else 0. seg and seg_neg are valid throughout.
  - frame_done = (idx == N-1 && cnt == DWELL-1).
- Frame-end update rules in SCAN:
  - A transfer with no frame end stores to the pending buffer and sets pending_flag, so in_ready = 0 from the next cycle.
  - At frame end with pending_flag set: active <= pending and pending_flag clears, so in_ready = 1 on the next cycle.
  - A transfer coinciding with frame end (pending_flag = 0) loads active directly. The new data shows from digit 0 of the next frame and pending_flag stays 0.
- Element decode:
  - SIGNED = 1: negative = element MSB. Magnitude = two's-complement negation in W+1 bits, so the most negative value displays correctly (W=2: -2 shows magnitude 2).
  - SIGNED = 0: negative = 0, magnitude = element.
  - seg_neg = negative of element idx.
- Glyphs (seg hex):
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Magnitudes 10..15 are handled per the optional feature.
- Reset mid-scan returns to BLANK on the next edge and discards both buffers.
- in_data is ignored when in_ready = 0; in_valid may stay high and the transfer is taken once in_ready returns.

Optional Feature:
- Macro: SEG7_HEX_EN.
- Defined: magnitudes 10..15 display A=77, b=7C, C=39, d=5E, E=79, F=71.
- Undefined: magnitudes 10..15 display a dash (seg = 40).
- Only reachable with SIGNED = 0 and W = 4.

Test Plan:
Bench configuration: N=4, W=2, SIGNED=1, DWELL=4, GUARD=1.
1. Reset held 2 cycles -> seg=00, digit_sel=0000, scanning=0, in_ready=1; hold outputs with in_valid=0 for 20 cycles.
2. Transfer in_data=8'b10_01_11_00 from BLANK -> next cycle idx=0, seg=3F, seg_neg=0, digit_sel=0000 for 1 cycle then 0001. Digits then read, in order:
   - digit 1: seg=06, seg_neg=1
   - digit 2: seg=06, seg_neg=0
   - digit 3: seg=5B, seg_neg=1
   - frame_done high only on cycle 16 of the frame.
3. Mid-frame transfer of 8'hFF -> in_ready=0 until frame end; the current frame is unchanged; the next frame shows all digits seg=06, seg_neg=1.
4. Transfer coinciding with frame_done -> new data shown from the next digit 0, in_ready stays 1.
5. Assert rst at idx=2, cnt=1 -> next cycle all outputs at reset values and state BLANK.
6. N=1, W=4, SIGNED=0, in_data=4'hB -> seg=7C with SEG7_HEX_EN, seg=40 without; in_data=4'h8 -> seg=7F in both builds.
